rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
- Hardware drawing engine on the write side of the framebuffer draw interface.
- Accepts one rectangle-fill command from the processor and emits one pixel write per Fast_Clock on Enable_Draw/Draw_X/Draw_Y/Draw_Color.
- Those outputs connect directly to the display block's draw inputs, so software no longer issues per-pixel stores.
- Provides clipping to the 160x120 framebuffer, a full-screen clear mode, abort, and a completion pulse.

Parameters:
FB_WIDTH, 160, framebuffer width in pixels
FB_HEIGHT, 120, framebuffer height in pixels
COLOR_BITS, 9, colour width (RGB 3:3:3)

Ports:
Fast_Clock  input  1  system clock; all logic is rising-edge
Reset  input  1  asynchronous, active-high reset
Cmd_Valid  input  1  command present
Cmd_Ready  output  1  engine can accept a command (high only in IDLE)
Cmd_Clear  input  1  ignore geometry and fill the full FB_WIDTHxFB_HEIGHT
Cmd_X0  input  8  left edge
Cmd_Y0  input  7  top edge
Cmd_W  input  8  width in pixels
Cmd_H  input  7  height in pixels
Cmd_Color  input  COLOR_BITS  fill colour
Abort  input  1  terminate the current fill
Enable_Draw  output  1  pixel write strobe
Draw_X  output  32  pixel x, zero-extended
Draw_Y  output  32  pixel y, zero-extended
Draw_Color  output  32  colour, zero-extended from COLOR_BITS
Busy  output  1  high in DRAW and DONE
Done  output  1  one-cycle pulse when a fill completes

Behaviour:
- Reset (async, any state): state=IDLE.
  - Outputs: Cmd_Ready=1, Busy=0, Done=0, Enable_Draw=0, Draw_X=0, Draw_Y=0, Draw_Color=0.
- States: IDLE, DRAW, DONE.
- IDLE, accept on Cmd_Valid & Cmd_Ready at a rising edge. At that edge the engine:
  - Latches the colour.
  - Computes clipped bounds: xs=X0, xe=min(X0+W, FB_WIDTH)-1, ys=Y0, ye=min(Y0+H, FB_HEIGHT)-1.
  - Sums are evaluated 9 bits wide (x) and 8 bits wide (y) so they cannot overflow.
  - If Cmd_Clear=1: xs=0, xe=FB_WIDTH-1, ys=0, ye=FB_HEIGHT-1.
  - Rectangle is empty if W=0, H=0, X0>=FB_WIDTH or Y0>=FB_HEIGHT (Cmd_Clear never empty).
  - Non-empty: go to DRAW with the counters at (xs,ys). Empty: go directly to DONE with no writes.
- DRAW:
  - Enable_Draw=1 every cycle; Draw_X/Draw_Y show the current counters; Draw_Color shows the latched colour.
  - Enable_Draw is combinational from state, so the first pixel appears the cycle after accept (latency 1).
  - Raster order: x increments each cycle. At x==xe, x wraps to xs and y increments.
  - At x==xe and y==ye, that cycle emits the last pixel, then the state goes to DONE.
  - Total write cycles = (xe-xs+1)*(ye-ys+1), with no gaps. A full clear takes 19200 cycles.
- DONE: Done=1 for exactly one cycle, Enable_Draw=0, then IDLE.
- Cmd_Ready=0 in DRAW and DONE. Cmd_Valid is ignored there, and commands are never queued.
- Abort:
  - Sampled in DRAW only. At the edge where Abort=1, go to IDLE, with Enable_Draw=0 from the next cycle.
  - The pixel displayed in the Abort cycle is still written.
  - No Done pulse. Abort in IDLE or DONE has no effect.
- Cmd_Valid and Abort both high in IDLE: the command is accepted (Abort is ignored in IDLE).
- Draw_X/Draw_Y hold their last value outside DRAW and are never outside the framebuffer while Enable_Draw=1.
- Reset asserted mid-DRAW: writes stop immediately (Enable_Draw falls asynchronously) and no Done is generated.

Test Plan:
- Reset, then Cmd X0=10,Y0=20,W=3,H=2,Color=0x1FF accepted at cycle 0 -> cycles 1..6 show Enable_Draw=1 at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 0x1FF. Done=1 at cycle 7; Cmd_Ready=1 at cycle 8.
- Clipping: X0=158,Y0=118,W=5,H=5 -> exactly 4 writes: (158,118),(159,118),(158,119),(159,119). No write has x>=160 or y>=120.
- Empty command W=0 (and separately X0=200) -> zero writes, Done at cycle 1, Busy high only during cycle 1.
- Cmd_Clear=1, colour 0x038 -> 19200 consecutive writes, first (0,0), last (159,119). Done one cycle after the last write. A scoreboard confirms each address is written once.
- Abort asserted on the 5th write cycle of a 10x10 fill -> exactly 5 writes, no Done pulse, Cmd_Ready=1 next cycle. A new command is then accepted normally.
- Reset asserted during a 4x4 fill at the 3rd write -> Enable_Draw=0 immediately, all outputs at reset values, no Done pulse. Cmd_Valid held high during DRAW is not accepted until IDLE.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: turns one fill command into a raster of pixel
// writes on the framebuffer draw port, with clipping, clear and abort.
module rect_fill_engine #(
  parameter int FB_WIDTH   = 160,
  parameter int FB_HEIGHT  = 120,
  parameter int COLOR_BITS = 9
) (
  input  logic                  Fast_Clock,
  input  logic                  Reset,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Clear,
  input  logic [7:0]            Cmd_X0,
  input  logic [6:0]            Cmd_Y0,
  input  logic [7:0]            Cmd_W,
  input  logic [6:0]            Cmd_H,
  input  logic [COLOR_BITS-1:0] Cmd_Color,
  input  logic                  Abort,
  output logic                  Enable_Draw,
  output logic [31:0]           Draw_X,
  output logic [31:0]           Draw_Y,
  output logic [31:0]           Draw_Color,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [8:0] FBW = 9'(FB_WIDTH);
  localparam logic [7:0] FBH = 8'(FB_HEIGHT);

  state_t                state_q, state_d;
  logic [7:0]            x_q, x_d;
  logic [6:0]            y_q, y_d;
  logic [7:0]            xs_q, xs_d;
  logic [7:0]            xe_q, xe_d;
  logic [6:0]            ye_q, ye_d;
  logic [COLOR_BITS-1:0] color_q, color_d;

  logic [8:0] x_sum, x_lim;
  logic [7:0] y_sum, y_lim;
  logic [7:0] cmd_xs, cmd_xe;
  logic [6:0] cmd_ys, cmd_ye;
  logic       cmd_empty;

  // Sums are one bit wider than the operands so clipping never overflows.
  always_comb begin
    x_sum     = {1'b0, Cmd_X0} + {1'b0, Cmd_W};
    y_sum     = {1'b0, Cmd_Y0} + {1'b0, Cmd_H};
    x_lim     = (x_sum > FBW) ? FBW : x_sum;
    y_lim     = (y_sum > FBH) ? FBH : y_sum;
    cmd_xs    = Cmd_X0;
    cmd_ys    = Cmd_Y0;
    cmd_xe    = 8'(x_lim - 9'd1);
    cmd_ye    = 7'(y_lim - 8'd1);
    cmd_empty = (Cmd_W == 8'd0) || (Cmd_H == 7'd0) ||
                ({1'b0, Cmd_X0} >= FBW) ||
                ({1'b0, Cmd_Y0} >= FBH);
    if (Cmd_Clear) begin
      cmd_xs    = 8'd0;
      cmd_ys    = 7'd0;
      cmd_xe    = 8'(FBW - 9'd1);
      cmd_ye    = 7'(FBH - 8'd1);
      cmd_empty = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (Cmd_Valid) begin
          color_d = Cmd_Color;
          if (cmd_empty) begin
            state_d = DONE;
          end else begin
            state_d = DRAW;
            xs_d    = cmd_xs;
            xe_d    = cmd_xe;
            ye_d    = cmd_ye;
            x_d     = cmd_xs;
            y_d     = cmd_ys;
          end
        end
      end
      DRAW: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (x_q == xe_q) begin
          // Last pixel keeps the counters so they hold (xe,ye) afterwards.
          if (y_q == ye_q) begin
            state_d = DONE;
          end else begin
            x_d = xs_q;
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      color_q <= color_d;
    end
  end

  assign Cmd_Ready   = (state_q == IDLE);
  assign Busy        = (state_q != IDLE);
  assign Done        = (state_q == DONE);
  assign Enable_Draw = (state_q == DRAW);
  assign Draw_X      = 32'(x_q);
  assign Draw_Y      = 32'(y_q);
  assign Draw_Color  = 32'(color_q);

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: table of fill commands with
// hand-computed clipped bounds, plus abort and reset sequences.
module tb_rect_fill_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [7:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [8:0]  cmd_color;
  logic        abort_i;
  logic        en;
  logic [31:0] dx;
  logic [31:0] dy;
  logic [31:0] dcol;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int hits [19200];

  rect_fill_engine #(
    .FB_WIDTH  (160),
    .FB_HEIGHT (120),
    .COLOR_BITS(9)
  ) dut (
    .Fast_Clock (clk),
    .Reset      (rst),
    .Cmd_Valid  (cmd_valid),
    .Cmd_Ready  (cmd_ready),
    .Cmd_Clear  (cmd_clear),
    .Cmd_X0     (cmd_x0),
    .Cmd_Y0     (cmd_y0),
    .Cmd_W      (cmd_w),
    .Cmd_H      (cmd_h),
    .Cmd_Color  (cmd_color),
    .Abort      (abort_i),
    .Enable_Draw(en),
    .Draw_X     (dx),
    .Draw_Y     (dy),
    .Draw_Color (dcol),
    .Busy       (busy),
    .Done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [8:0] col;
    int         xs;
    int         xe;
    int         ys;
    int         ye;
    int         n;
  } vec_t;

  vec_t tv [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic [7:0] x0,
                       input logic [6:0] y0, input logic [7:0] w,
                       input logic [6:0] h, input logic [8:0] col);
    cmd_clear = clr;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_w     = w;
    cmd_h     = h;
    cmd_color = col;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ex;
    int ey;
    int bad;
    int sb_bad;
    ex  = v.xs;
    ey  = v.ys;
    bad = 0;
    if (v.clr) foreach (hits[i]) hits[i] = 0;
    chk($sformatf("v%0d_ready", idx), 32'(cmd_ready), 32'd1);
    drive(v.clr, v.x0, v.y0, v.w, v.h, v.col);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      if (!(en && busy && !cmd_ready && !done &&
            dx == 32'(ex) && dy == 32'(ey) &&
            dcol == 32'(v.col) && dx < 160 && dy < 120))
        bad++;
      if (v.clr && dx < 160 && dy < 120)
        hits[int'(dy) * 160 + int'(dx)]++;
      tick();
      if (ex == v.xe) begin
        ex = v.xs;
        ey++;
      end else begin
        ex++;
      end
    end
    chk($sformatf("v%0d_pixels_bad", idx), 32'(bad), 32'd0);
    chk($sformatf("v%0d_done_cycle", idx),
        {28'd0, done, en, busy, cmd_ready}, 32'b1010);
    if (v.n > 0) begin
      chk($sformatf("v%0d_hold_xy", idx), {dx[15:0], dy[15:0]},
          {16'(v.xe), 16'(v.ye)});
    end
    tick();
    chk($sformatf("v%0d_idle", idx),
        {28'd0, done, en, busy, cmd_ready}, 32'b0001);
    if (v.clr) begin
      sb_bad = 0;
      foreach (hits[i]) if (hits[i] != 1) sb_bad++;
      chk($sformatf("v%0d_scoreboard", idx), 32'(sb_bad), 32'd0);
    end
  endtask

  initial begin
    int wr;
    int bad;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    abort_i   = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 9'd0);

    tv[0] = '{1'b0, 8'd10,  7'd20,  8'd3,   7'd2,   9'h1FF, 10,  12,  20,  21,  6};
    tv[1] = '{1'b0, 8'd158, 7'd118, 8'd5,   7'd5,   9'h0AA, 158, 159, 118, 119, 4};
    tv[2] = '{1'b0, 8'd5,   7'd5,   8'd0,   7'd4,   9'h011, 0,   0,   0,   0,   0};
    tv[3] = '{1'b0, 8'd200, 7'd5,   8'd4,   7'd4,   9'h022, 0,   0,   0,   0,   0};
    tv[4] = '{1'b0, 8'd5,   7'd120, 8'd4,   7'd3,   9'h033, 0,   0,   0,   0,   0};
    tv[5] = '{1'b0, 8'd5,   7'd5,   8'd4,   7'd0,   9'h044, 0,   0,   0,   0,   0};
    tv[6] = '{1'b0, 8'd0,   7'd0,   8'd1,   7'd1,   9'h001, 0,   0,   0,   0,   1};
    tv[7] = '{1'b0, 8'd100, 7'd50,  8'd255, 7'd127, 9'h123, 100, 159, 50,  119, 4200};
    tv[8] = '{1'b1, 8'd200, 7'd0,   8'd0,   7'd0,   9'h038, 0,   159, 0,   119, 19200};

    #3;
    chk("reset_flags", {28'd0, done, en, busy, cmd_ready}, 32'b0001);
    chk("reset_xyc", dx | dy | dcol, 32'd0);
    #4 rst = 1'b0;
    tick();

    foreach (tv[i]) run_vec(tv[i], i);

    // Abort on the 5th write of a 10x10 fill.
    drive(1'b0, 8'd30, 7'd40, 8'd10, 7'd10, 9'h155);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wr = 0;
    for (int c = 0; c < 5; c++) begin
      if (en) wr++;
      if (c == 4) begin
        chk("abort_5th_pix", {dx[15:0], dy[15:0]}, {16'd34, 16'd40});
        abort_i = 1'b1;
      end
      tick();
    end
    abort_i = 1'b0;
    chk("abort_writes", 32'(wr), 32'd5);
    chk("abort_after", {28'd0, done, en, busy, cmd_ready}, 32'b0001);
    chk("abort_hold_x", dx, 32'd34);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (done || en) bad++;
      tick();
    end
    chk("abort_no_done", 32'(bad), 32'd0);
    run_vec(tv[6], 6);

    // Abort high together with a command in IDLE is ignored.
    abort_i = 1'b1;
    drive(1'b0, 8'd50, 7'd60, 8'd2, 7'd1, 9'h0C3);
    cmd_valid = 1'b1;
    tick();
    abort_i   = 1'b0;
    cmd_valid = 1'b0;
    chk("idle_abort_pix0", {15'd0, en, dx[7:0], dy[7:0]},
        {15'd0, 1'b1, 8'd50, 8'd60});
    tick();
    chk("idle_abort_pix1", {15'd0, en, dx[7:0], dy[7:0]},
        {15'd0, 1'b1, 8'd51, 8'd60});
    tick();
    chk("idle_abort_done", {28'd0, done, en, busy, cmd_ready}, 32'b1010);
    tick();

    // Reset at the 3rd write of a 4x4 fill, Cmd_Valid held throughout.
    drive(1'b0, 8'd0, 7'd0, 8'd4, 7'd4, 9'h0F0);
    cmd_valid = 1'b1;
    tick();
    chk("hold_valid_not_ready", 32'(cmd_ready), 32'd0);
    tick();
    tick();
    chk("rst_3rd_pix", {15'd0, en, dx[7:0], dy[7:0]},
        {15'd0, 1'b1, 8'd2, 8'd0});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flags", {28'd0, done, en, busy, cmd_ready}, 32'b0001);
    chk("rst_mid_xyc", dx | dy | dcol, 32'd0);
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || en || !cmd_ready) bad++;
    end
    chk("rst_no_done", 32'(bad), 32'd0);
    run_vec(tv[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
